// File: rtl/bpu_update_sched_if.sv
// Port bundle between execute-stage branch resolution, the update scheduler and
// the predictor's single BTB/PHT write port.
interface bpu_update_sched_if #(
    parameter int IDX_W = 9,
    parameter int TAG_W = 8
);
    logic             a_valid;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             a_taken;
    logic [29:0]      a_target;
    logic [1:0]       a_type;
    logic             b_valid;
    logic [IDX_W-1:0] b_idx;
    logic [TAG_W-1:0] b_tag;
    logic             b_taken;
    logic [29:0]      b_target;
    logic [1:0]       b_type;
    logic             clear_req;
    logic             in_space;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_clear;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_taken;
    logic [29:0]      wr_target;
    logic [1:0]       wr_type;
    logic             busy_clear;
    logic [15:0]      drop_cnt;

    modport master (
        output a_valid, a_idx, a_tag, a_taken, a_target, a_type,
        output b_valid, b_idx, b_tag, b_taken, b_target, b_type,
        output clear_req, wr_ready,
        input  in_space, wr_valid, wr_clear, wr_idx, wr_tag, wr_taken, wr_target, wr_type,
        input  busy_clear, drop_cnt
    );

    modport slave (
        input  a_valid, a_idx, a_tag, a_taken, a_target, a_type,
        input  b_valid, b_idx, b_tag, b_taken, b_target, b_type,
        input  clear_req, wr_ready,
        output in_space, wr_valid, wr_clear, wr_idx, wr_tag, wr_taken, wr_target, wr_type,
        output busy_clear, drop_cnt
    );
endinterface

// File: rtl/bpu_update_sched.sv
// Branch predictor update scheduler: buffers up to two resolved-branch updates per
// cycle in an in-order FIFO, drains one per cycle, and sequences full-table clears.
module bpu_update_sched #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 9,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    bpu_update_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [29:0]      target;
        logic [1:0]       jtype;
    } entry_t;

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_r;
    logic [IDX_W-1:0] clr_ptr_r;
    entry_t           mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic [15:0]      drop_cnt_r;

    entry_t           a_ent_s;
    entry_t           b_ent_s;
    entry_t           first_s;
    entry_t           second_s;
    entry_t           head_s;
    logic             pop_s;
    logic             merge_s;
    logic             push1_s;
    logic             push2_s;
    logic [1:0]       drop_s;
    logic [AW+1:0]    free_s;
    logic [16:0]      drop_sum_s;

    // Enqueue decision: merge same-index lanes, lane 1 first, pop credit counts as free.
    always_comb begin
        a_ent_s  = '{bus.a_idx, bus.a_tag, bus.a_taken, bus.a_target, bus.a_type};
        b_ent_s  = '{bus.b_idx, bus.b_tag, bus.b_taken, bus.b_target, bus.b_type};
        pop_s    = (state_r == ST_RUN) && (count_r != '0) && bus.wr_ready;
        free_s   = (AW+2)'(DEPTH) - {1'b0, count_r} + {{(AW+1){1'b0}}, pop_s};
        merge_s  = bus.a_valid && bus.b_valid && (bus.a_idx == bus.b_idx);
        first_s  = a_ent_s;
        second_s = b_ent_s;
        push1_s  = 1'b0;
        push2_s  = 1'b0;
        drop_s   = 2'd0;
        if (merge_s || (bus.b_valid && !bus.a_valid)) begin
            first_s = b_ent_s;
            if (free_s != '0) begin
                push1_s = 1'b1;
            end else begin
                drop_s = 2'd1;
            end
        end else if (bus.a_valid && bus.b_valid) begin
            if (free_s >= (AW+2)'(2)) begin
                push1_s = 1'b1;
                push2_s = 1'b1;
            end else if (free_s == (AW+2)'(1)) begin
                push1_s = 1'b1;
                drop_s  = 2'd1;
            end else begin
                drop_s = 2'd2;
            end
        end else if (bus.a_valid) begin
            if (free_s != '0) begin
                push1_s = 1'b1;
            end else begin
                drop_s = 2'd1;
            end
        end else begin
            push1_s = 1'b0;
        end
        drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drop_s};
    end

    // Control state: clear walk / run FSM, FIFO pointers and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_CLEAR;
            clr_ptr_r  <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            drop_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (bus.clear_req) begin
                        clr_ptr_r <= '0;
                    end else if (bus.wr_ready) begin
                        if (clr_ptr_r == '1) begin
                            state_r   <= ST_RUN;
                            clr_ptr_r <= '0;
                        end else begin
                            clr_ptr_r <= clr_ptr_r + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.clear_req) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= '0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= '0;
                end
            endcase
            rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
            wr_ptr_r   <= wr_ptr_r + AW'(push1_s) + AW'(push2_s);
            count_r    <= count_r + (AW+1)'(push1_s) + (AW+1)'(push2_s) - (AW+1)'(pop_s);
            drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push1_s) begin
            mem_r[wr_ptr_r] <= first_s;
        end
        if (push2_s) begin
            mem_r[wr_ptr_r + AW'(1)] <= second_s;
        end
    end

    // Write port driven purely from registered state.
    always_comb begin
        head_s        = mem_r[rd_ptr_r];
        bus.wr_valid  = 1'b0;
        bus.wr_clear  = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_tag    = '0;
        bus.wr_taken  = 1'b0;
        bus.wr_target = 30'd0;
        bus.wr_type   = 2'd0;
        case (state_r)
            ST_CLEAR: begin
                bus.wr_valid = 1'b1;
                bus.wr_clear = 1'b1;
                bus.wr_idx   = clr_ptr_r;
            end
            ST_RUN: begin
                bus.wr_valid  = (count_r != '0);
                bus.wr_idx    = head_s.idx;
                bus.wr_tag    = head_s.tag;
                bus.wr_taken  = head_s.taken;
                bus.wr_target = head_s.target;
                bus.wr_type   = head_s.jtype;
            end
            default: begin
                bus.wr_valid = 1'b0;
            end
        endcase
    end

    assign bus.busy_clear = (state_r == ST_CLEAR);
    assign bus.in_space   = ((AW+2)'(DEPTH) - {1'b0, count_r}) >= (AW+2)'(2);
    assign bus.drop_cnt   = drop_cnt_r;
endmodule

// File: tb/tb_bpu_update_sched.sv
// Scoreboard bench for bpu_update_sched: a queue-based reference model predicts
// each table write and the status outputs; a negedge monitor compares them.
module tb_bpu_update_sched;
    localparam int DEPTH = 4;
    localparam int IDX_W = 9;
    localparam int TAG_W = 8;
    localparam int NIDX  = 1 << IDX_W;

    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [29:0]      target;
        logic [1:0]       jtype;
    } upd_t;

    typedef struct packed {
        logic             clr;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [29:0]      target;
        logic [1:0]       jtype;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    bpu_update_sched_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus();
    bpu_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    wr_t  sb[$];
    wr_t  mq[$];
    bit   m_clear;
    int   m_ptr;
    int   m_drop;
    bit   chk_en = 1'b0;
    bit   cur_valid, cur_busy, cur_space;
    int   cur_drop;
    upd_t idle_u = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic upd_t mk(input int idx, input int tag, input bit taken, input int target, input int jt);
        upd_t u;
        u.v = 1'b1; u.idx = IDX_W'(idx); u.tag = TAG_W'(tag); u.taken = taken;
        u.target = 30'(target); u.jtype = 2'(jt);
        return u;
    endfunction

    function automatic upd_t rnd_upd();
        upd_t u;
        u.v = 1'($urandom_range(0, 1)); u.idx = IDX_W'($urandom_range(0, 3));
        u.tag = TAG_W'($urandom); u.taken = 1'($urandom_range(0, 1));
        u.target = 30'($urandom); u.jtype = 2'($urandom_range(0, 2));
        return u;
    endfunction

    // Model: a lane update takes a slot if any is left, else it is counted as dropped.
    task automatic push_upd(input upd_t u);
        if (mq.size() < DEPTH) mq.push_back('{1'b0, u.idx, u.tag, u.taken, u.target, u.jtype});
        else if (m_drop < 65535) m_drop++;
    endtask

    task automatic apply(input upd_t a, input upd_t b, input bit clr, input bit rdy);
        bus.a_valid = a.v; bus.a_idx = a.idx; bus.a_tag = a.tag; bus.a_taken = a.taken;
        bus.a_target = a.target; bus.a_type = a.jtype;
        bus.b_valid = b.v; bus.b_idx = b.idx; bus.b_tag = b.tag; bus.b_taken = b.taken;
        bus.b_target = b.target; bus.b_type = b.jtype;
        bus.clear_req = clr; bus.wr_ready = rdy;
        cur_valid = m_clear || (mq.size() > 0);
        cur_busy  = m_clear;
        cur_space = (DEPTH - mq.size()) >= 2;
        cur_drop  = m_drop;
        if (cur_valid && rdy) begin
            if (m_clear) sb.push_back('{1'b1, IDX_W'(m_ptr), TAG_W'(0), 1'b0, 30'd0, 2'd0});
            else sb.push_back(mq.pop_front());
        end
        if (a.v && b.v && a.idx == b.idx) push_upd(b);
        else begin
            if (a.v) push_upd(a);
            if (b.v) push_upd(b);
        end
        if (clr) begin
            m_clear = 1'b1; m_ptr = 0;
        end else if (m_clear && rdy) begin
            if (m_ptr == NIDX - 1) begin m_clear = 1'b0; m_ptr = 0; end
            else m_ptr++;
        end
    endtask

    task automatic cycle(input upd_t a, input upd_t b, input bit clr, input bit rdy);
        @(posedge clk); #1;
        apply(a, b, clr, rdy);
    endtask

    task automatic do_reset(input bit rdy);
        @(posedge clk); #1;
        chk_en = 1'b0; reset = 1'b1;
        apply(idle_u, idle_u, 1'b0, 1'b0);
        @(posedge clk); #1;
        mq.delete(); sb.delete();
        m_clear = 1'b1; m_ptr = 0; m_drop = 0;
        cur_valid = 1'b1; cur_busy = 1'b1; cur_space = 1'b1; cur_drop = 0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        apply(idle_u, idle_u, 1'b0, rdy);
    endtask

    // Monitor: status every cycle, payload on each handshake against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_valid", 64'(bus.wr_valid), 64'(cur_valid));
            check("busy_clear", 64'(bus.busy_clear), 64'(cur_busy));
            check("in_space", 64'(bus.in_space), 64'(cur_space));
            check("drop_cnt", 64'(bus.drop_cnt), 64'(cur_drop));
            if (bus.wr_valid && bus.wr_ready) begin
                check("write_expected", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_payload", 64'({bus.wr_clear, bus.wr_idx, bus.wr_tag, bus.wr_taken,
                                             bus.wr_target, bus.wr_type}), 64'(e));
                end
            end
            check("write_missing", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    end

    initial begin
        reset = 1'b1;
        apply(idle_u, idle_u, 1'b0, 1'b0);
        // Full clear walk out of reset, then idle with an empty FIFO.
        do_reset(1'b1);
        repeat (NIDX + 3) cycle(idle_u, idle_u, 1'b0, 1'b1);
        // Single update passes straight through.
        cycle(mk('h10, 'h5, 1'b1, 'h100, 0), idle_u, 1'b0, 1'b1);
        repeat (2) cycle(idle_u, idle_u, 1'b0, 1'b1);
        // Same-index merge keeps only lane 2.
        cycle(mk('h20, 'h1, 1'b0, 'h1, 1), mk('h20, 'h2, 1'b1, 'h2, 2), 1'b0, 1'b1);
        repeat (2) cycle(idle_u, idle_u, 1'b0, 1'b1);
        // Fill with write port stalled; third dual cycle drops both lanes.
        cycle(mk('h30, 'h11, 1'b1, 'h31, 0), mk('h31, 'h12, 1'b0, 'h32, 1), 1'b0, 1'b0);
        cycle(mk('h32, 'h13, 1'b1, 'h33, 2), mk('h33, 'h14, 1'b1, 'h34, 0), 1'b0, 1'b0);
        cycle(mk('h34, 'h15, 1'b0, 'h35, 1), mk('h35, 'h16, 1'b1, 'h36, 2), 1'b0, 1'b0);
        cycle(idle_u, idle_u, 1'b0, 1'b0);
        // Full FIFO: pop and push in the same cycle, no drop.
        cycle(mk('h40, 'h17, 1'b1, 'h41, 1), idle_u, 1'b0, 1'b1);
        repeat (6) cycle(idle_u, idle_u, 1'b0, 1'b1);
        // Two queued entries survive a clear walk, then drain in order.
        cycle(mk('h50, 'h21, 1'b1, 'h51, 0), mk('h51, 'h22, 1'b0, 'h52, 1), 1'b0, 1'b0);
        cycle(idle_u, idle_u, 1'b1, 1'b0);
        repeat (NIDX + 5) cycle(idle_u, idle_u, 1'b0, 1'b1);
        // Randomized traffic with stalls and occasional clears.
        for (int i = 0; i < 300; i++)
            cycle(rnd_upd(), rnd_upd(), 1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0));
        // Reset mid-activity, restart the walk partway through, then random traffic.
        do_reset(1'b1);
        repeat (100) cycle(idle_u, idle_u, 1'b0, 1'b1);
        cycle(idle_u, idle_u, 1'b1, 1'b1);
        for (int i = 0; i < 700; i++)
            cycle(rnd_upd(), rnd_upd(), 1'b0, 1'($urandom_range(0, 2) != 0));
        repeat (NIDX + 8) cycle(idle_u, idle_u, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
